// File: rtl/add_arbiter.sv
// Two-requester front end for a shared N-bit adder: round-robin grant, operand
// capture, one execute cycle, and a held response with a valid/ready handshake.

module add_core #(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         carry,
  output logic         ovf
);
  logic [N:0] s;

  assign s     = {1'b0, a} + {1'b0, b};
  assign sum   = s[N-1:0];
  assign carry = s[N];
  // Like-signed operands whose sum flips sign overflowed in two's complement.
  assign ovf   = (a[N-1] == b[N-1]) && (s[N-1] != a[N-1]);
endmodule

module add_arbiter #(
  parameter int N     = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [N-1:0]     a0,
  input  logic [N-1:0]     b0,
  input  logic             req1,
  input  logic [N-1:0]     a1,
  input  logic [N-1:0]     b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [N-1:0]     rsp_sum,
  output logic             rsp_carry,
  output logic             rsp_ovf,
  output logic             rsp_id,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t         state_q, state_d;
  logic           ptr_q;
  logic [N-1:0]   op_a_q, op_b_q;
  logic           op_id_q;
  logic [N-1:0]   ex_sum;
  logic           ex_carry, ex_ovf;
  logic           accept;

  assign accept = rsp_valid && rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt0 || gnt1) state_d = EXEC;
      EXEC:    state_d = DONE;
      DONE:    if (accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grants are gated by rst so nothing is accepted in a reset cycle.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst && state_q == IDLE) begin
      if (req0 && req1) begin
        gnt0 = ~ptr_q;
        gnt1 = ptr_q;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
    busy = (state_q != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a_q  <= '0;
      op_b_q  <= '0;
      op_id_q <= 1'b0;
    end else if (gnt0 || gnt1) begin
      op_a_q  <= gnt1 ? a1 : a0;
      op_b_q  <= gnt1 ? b1 : b0;
      op_id_q <= gnt1;
    end
  end

  add_core #(.N(N)) u_core (
    .a     (op_a_q),
    .b     (op_b_q),
    .sum   (ex_sum),
    .carry (ex_carry),
    .ovf   (ex_ovf)
  );

  // Pointer moves only when a response is consumed, never on grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_carry <= 1'b0;
      rsp_ovf   <= 1'b0;
      rsp_id    <= 1'b0;
      op_count  <= '0;
      ptr_q     <= 1'b0;
    end else if (state_q == EXEC) begin
      rsp_valid <= 1'b1;
      rsp_sum   <= ex_sum;
      rsp_carry <= ex_carry;
      rsp_ovf   <= ex_ovf;
      rsp_id    <= op_id_q;
    end else if (accept) begin
      rsp_valid <= 1'b0;
      op_count  <= op_count + 1'b1;
      ptr_q     <= ~rsp_id;
    end
  end
endmodule
